freelist: RTL and testbench

//  Circular FIFO of free physical-register tags that feeds the dispatch stage.
//  - Dispatch takes up to C_DP_NUM new rd tags per cycle; the map table then installs them.
//  - Retire returns up to C_RT_NUM tag_old values per cycle.
//  - On rollback_i the list is restored to exactly the tags not held by the architectural map table.

---
 rtl/freelist_pkg.sv | 56 +++++
 rtl/freelist.sv | 110 +++++++++++
 tb/tb_freelist.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/freelist_pkg.sv
// Free-list types, sizes and helpers shared by rename/dispatch/retire.
// The bypass option is selected with the FL_RT_BYPASS_EN macro.
`ifndef DP_NUM
`define DP_NUM 2
`endif
`ifndef RT_NUM
`define RT_NUM 2
`endif
`ifndef ARCH_REG_NUM
`define ARCH_REG_NUM 32
`endif
`ifndef FL_ENTRY_NUM
`define FL_ENTRY_NUM 32
`endif
`ifndef TAG_IDX_WIDTH
`define TAG_IDX_WIDTH 6
`endif

package freelist_pkg;

   localparam int C_DP_NUM        = `DP_NUM;
   localparam int C_RT_NUM        = `RT_NUM;
   localparam int C_ARCH_REG_NUM  = `ARCH_REG_NUM;
   localparam int C_FL_ENTRY      = `FL_ENTRY_NUM;
   localparam int C_TAG_IDX_WIDTH = `TAG_IDX_WIDTH;

   localparam int C_FL_IDX_W = $clog2(C_FL_ENTRY);
   localparam int C_FL_PTR_W = C_FL_IDX_W + 1;
   localparam int C_DP_CNT_W = $clog2(C_DP_NUM + 1);
   localparam int C_RT_CNT_W = $clog2(C_RT_NUM + 1);
   localparam int C_RT_IDX_W =
      (C_RT_NUM > 1) ? $clog2(C_RT_NUM) : 1;

   typedef logic [C_TAG_IDX_WIDTH-1:0] tag_t;
   typedef logic [C_FL_PTR_W-1:0]      fl_ptr_t;
   typedef logic [C_FL_IDX_W-1:0]      fl_idx_t;

   typedef struct packed {
      logic [C_DP_CNT_W-1:0] dp_num;
   } DP_FL;

   typedef struct packed {
      logic [C_DP_NUM-1:0][C_TAG_IDX_WIDTH-1:0] tag;
      logic [C_DP_CNT_W-1:0]                    avail_num;
   } FL_DP;

   typedef struct packed {
      logic [C_RT_CNT_W-1:0]                    rt_num;
      logic [C_RT_NUM-1:0][C_TAG_IDX_WIDTH-1:0] tag;
   } RT_FL;

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/freelist.sv
// Circular FIFO of free physical tags between retire and dispatch.
// Define FL_RT_BYPASS_EN to forward same-cycle retire tags when short.
module freelist
   import freelist_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic rollback_i,
   input  DP_FL dp_fl_i,
   output FL_DP fl_dp_o,
   input  RT_FL rt_fl_i
);

   tag_t    entry [C_FL_ENTRY];
   fl_ptr_t head_ptr;
   fl_ptr_t tail_ptr;
   fl_ptr_t head_next;
   fl_ptr_t tail_next;
   fl_ptr_t count;
   fl_idx_t rd_idx;

   logic [C_RT_IDX_W-1:0] byp_idx;
   logic byp_on;
   logic overpop;
   logic overflow;

   int cnt;
   int rt_n;
   int dp_n;
   int avail_n;
   int pop_n;
   int byp_n;

   assign count = tail_ptr - head_ptr;

   // Offer head tags (plus optional retire forwarding) and compute next pointers.
   always_comb begin
      fl_dp_o = '0;
      rd_idx  = '0;
      byp_idx = '0;
      byp_on  = 1'b0;
      cnt     = int'(count);
      rt_n    = int'(rt_fl_i.rt_num);
      dp_n    = int'(dp_fl_i.dp_num);
      avail_n = min_int(cnt, C_DP_NUM);
`ifdef FL_RT_BYPASS_EN
      byp_on = !rollback_i && (cnt < C_DP_NUM);
      if (byp_on) begin
         avail_n = min_int(cnt + rt_n, C_DP_NUM);
      end
`endif
      for (int i = 0; i < C_DP_NUM; i++) begin
         rd_idx = head_ptr[C_FL_IDX_W-1:0] + C_FL_IDX_W'(i);
         byp_idx = C_RT_IDX_W'(i - cnt);
         if (i < avail_n && i < cnt) begin
            fl_dp_o.tag[i] = entry[rd_idx];
         end else if (i < avail_n && byp_on) begin
            fl_dp_o.tag[i] = rt_fl_i.tag[byp_idx];
         end
      end
      fl_dp_o.avail_num = C_DP_CNT_W'(avail_n);

      // Illegal over-pop is clamped to what is offered.
      overpop = !rollback_i && (dp_n > avail_n);
      pop_n   = min_int(dp_n, avail_n);
      if (rollback_i) begin
         pop_n = 0;
      end
      // Popped tags beyond the stored count came straight from retire.
      byp_n = (pop_n > cnt) ? pop_n - cnt : 0;

      overflow  = (cnt - pop_n + rt_n) > C_FL_ENTRY;
      tail_next = tail_ptr + C_FL_PTR_W'(rt_n);
      if (rollback_i) begin
         head_next = {~tail_next[C_FL_PTR_W-1],
                      tail_next[C_FL_IDX_W-1:0]};
      end else begin
         head_next = head_ptr + C_FL_PTR_W'(pop_n);
      end
   end

   // Tag storage and pointer update; reset refills with all non-arch tags.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < C_FL_ENTRY; k++) begin
            entry[k] <= C_TAG_IDX_WIDTH'(C_ARCH_REG_NUM + k);
         end
         head_ptr <= '0;
         tail_ptr <= {1'b1, {C_FL_IDX_W{1'b0}}};
      end else begin
         for (int j = 0; j < C_RT_NUM; j++) begin
            if (j < rt_n && j >= byp_n) begin
               entry[tail_ptr[C_FL_IDX_W-1:0] + C_FL_IDX_W'(j)]
                  <= rt_fl_i.tag[j];
            end
         end
         head_ptr <= head_next;
         tail_ptr <= tail_next;
      end
   end

   a_no_overpop : assert property (
      @(posedge clk_i) disable iff (rst_i) !overpop
   ) else $warning("freelist: dp_num above avail_num, pop clamped");

   a_no_overflow : assert property (
      @(posedge clk_i) disable iff (rst_i) !overflow
   ) else $error("freelist: retire push overflows the list");

endmodule

// File: tb/tb_freelist.sv
// Directed bench for the free list: reset, drain, push, wrap,
// rollback and reset priority.
module tb_freelist;
   import freelist_pkg::*;

   logic clk_i = 1'b0;
   logic rst_i;
   logic rollback_i;
   DP_FL dp_fl_i;
   FL_DP fl_dp_o;
   RT_FL rt_fl_i;

   int n_pass  = 0;
   int n_total = 0;

   freelist u_dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rollback_i (rollback_i),
      .dp_fl_i    (dp_fl_i),
      .fl_dp_o    (fl_dp_o),
      .rt_fl_i    (rt_fl_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic drive(input int dp, input int rn,
                        input int t0, input int t1);
      dp_fl_i.dp_num = C_DP_CNT_W'(dp);
      rt_fl_i.rt_num = C_RT_CNT_W'(rn);
      rt_fl_i.tag[0] = C_TAG_IDX_WIDTH'(t0);
      rt_fl_i.tag[1] = C_TAG_IDX_WIDTH'(t1);
   endtask

   task automatic idle();
      rst_i = 1'b0;
      rollback_i = 1'b0;
      drive(0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      idle();
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick();
      n_total++;
      if (fl_dp_o.avail_num !== 2'd2)
         $display("FAIL reset_avail got %0d want 2",
                  fl_dp_o.avail_num);
      else n_pass++;
      n_total++;
      if (fl_dp_o.tag[0] !== 6'd32 || fl_dp_o.tag[1] !== 6'd33)
         $display("FAIL reset_tags got %0d,%0d want 32,33",
                  fl_dp_o.tag[0], fl_dp_o.tag[1]);
      else n_pass++;
   endtask

   task automatic test_drain();
      for (int k = 0; k < 16; k++) begin
         n_total++;
         if (fl_dp_o.avail_num !== 2'd2 ||
             fl_dp_o.tag[0] !== 6'(32 + 2 * k) ||
             fl_dp_o.tag[1] !== 6'(33 + 2 * k))
            $display("FAIL drain_%0d got %0d:%0d,%0d want 2:%0d,%0d",
                     k, fl_dp_o.avail_num, fl_dp_o.tag[0],
                     fl_dp_o.tag[1], 32 + 2 * k, 33 + 2 * k);
         else n_pass++;
         drive(2, 0, 0, 0);
         tick();
      end
      n_total++;
      if (fl_dp_o.avail_num !== 2'd0 ||
          fl_dp_o.tag[0] !== 6'd0 || fl_dp_o.tag[1] !== 6'd0)
         $display("FAIL empty got %0d:%0d,%0d want 0:0,0",
                  fl_dp_o.avail_num, fl_dp_o.tag[0], fl_dp_o.tag[1]);
      else n_pass++;
      drive(1, 0, 0, 0);
      tick();
      n_total++;
      if (fl_dp_o.avail_num !== 2'd0)
         $display("FAIL overpop_clamp got %0d want 0",
                  fl_dp_o.avail_num);
      else n_pass++;
   endtask

   task automatic test_push_empty();
      drive(0, 2, 5, 9);
      #1;
      n_total++;
`ifdef FL_RT_BYPASS_EN
      if (fl_dp_o.avail_num !== 2'd2 ||
          fl_dp_o.tag[0] !== 6'd5 || fl_dp_o.tag[1] !== 6'd9)
         $display("FAIL bypass_same got %0d:%0d,%0d want 2:5,9",
                  fl_dp_o.avail_num, fl_dp_o.tag[0], fl_dp_o.tag[1]);
      else n_pass++;
`else
      if (fl_dp_o.avail_num !== 2'd0 || fl_dp_o.tag[0] !== 6'd0)
         $display("FAIL push_same got %0d:%0d want 0:0",
                  fl_dp_o.avail_num, fl_dp_o.tag[0]);
      else n_pass++;
`endif
      tick();
      n_total++;
      if (fl_dp_o.avail_num !== 2'd2 ||
          fl_dp_o.tag[0] !== 6'd5 || fl_dp_o.tag[1] !== 6'd9)
         $display("FAIL push_next got %0d:%0d,%0d want 2:5,9",
                  fl_dp_o.avail_num, fl_dp_o.tag[0], fl_dp_o.tag[1]);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int e0;
      int e1;
      for (int c = 0; c < 14; c++) begin
         e0 = (c == 0) ? 5 : c + 9;
         e1 = (c == 0) ? 9 : c + 29;
         n_total++;
         if (fl_dp_o.avail_num !== 2'd2 ||
             fl_dp_o.tag[0] !== 6'(e0) || fl_dp_o.tag[1] !== 6'(e1))
            $display("FAIL b2b_%0d got %0d:%0d,%0d want 2:%0d,%0d",
                     c, fl_dp_o.avail_num, fl_dp_o.tag[0],
                     fl_dp_o.tag[1], e0, e1);
         else n_pass++;
         drive(2, 2, c + 10, c + 30);
         tick();
      end
      drive(2, 1, 50, 0);
      tick();
      n_total++;
      if (fl_dp_o.avail_num !== 2'd1 ||
          fl_dp_o.tag[0] !== 6'd50 || fl_dp_o.tag[1] !== 6'd0)
         $display("FAIL count1 got %0d:%0d,%0d want 1:50,0",
                  fl_dp_o.avail_num, fl_dp_o.tag[0], fl_dp_o.tag[1]);
      else n_pass++;
   endtask

   task automatic test_wrap();
      drive(1, 2, 40, 41);
      tick();
      n_total++;
      if (fl_dp_o.avail_num !== 2'd2 ||
          fl_dp_o.tag[0] !== 6'd40 || fl_dp_o.tag[1] !== 6'd41)
         $display("FAIL wrap got %0d:%0d,%0d want 2:40,41",
                  fl_dp_o.avail_num, fl_dp_o.tag[0], fl_dp_o.tag[1]);
      else n_pass++;
      drive(2, 0, 0, 0);
      tick();
      n_total++;
      if (fl_dp_o.avail_num !== 2'd0)
         $display("FAIL wrap_drain got %0d want 0",
                  fl_dp_o.avail_num);
      else n_pass++;
   endtask

   task automatic test_rollback();
      rst_i = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) begin
         drive(2, 0, 0, 0);
         tick();
      end
      n_total++;
      if (fl_dp_o.tag[0] !== 6'd42 || fl_dp_o.tag[1] !== 6'd43)
         $display("FAIL pop10 got %0d,%0d want 42,43",
                  fl_dp_o.tag[0], fl_dp_o.tag[1]);
      else n_pass++;
      rollback_i = 1'b1;
      drive(2, 1, 7, 0);
      tick();
      n_total++;
      if (fl_dp_o.avail_num !== 2'd2 ||
          fl_dp_o.tag[0] !== 6'd33 || fl_dp_o.tag[1] !== 6'd34)
         $display("FAIL rollback got %0d:%0d,%0d want 2:33,34",
                  fl_dp_o.avail_num, fl_dp_o.tag[0], fl_dp_o.tag[1]);
      else n_pass++;
      for (int k = 0; k < 15; k++) begin
         drive(2, 0, 0, 0);
         tick();
      end
      n_total++;
      if (fl_dp_o.avail_num !== 2'd2 ||
          fl_dp_o.tag[0] !== 6'd63 || fl_dp_o.tag[1] !== 6'd7)
         $display("FAIL rb_tail got %0d:%0d,%0d want 2:63,7",
                  fl_dp_o.avail_num, fl_dp_o.tag[0], fl_dp_o.tag[1]);
      else n_pass++;
      drive(2, 0, 0, 0);
      tick();
      n_total++;
      if (fl_dp_o.avail_num !== 2'd0)
         $display("FAIL rb_count32 got %0d want 0",
                  fl_dp_o.avail_num);
      else n_pass++;
   endtask

   task automatic test_reset_priority();
      rst_i = 1'b1;
      rollback_i = 1'b1;
      drive(2, 2, 1, 2);
      tick();
      n_total++;
      if (fl_dp_o.avail_num !== 2'd2 ||
          fl_dp_o.tag[0] !== 6'd32 || fl_dp_o.tag[1] !== 6'd33)
         $display("FAIL rst_prio got %0d:%0d,%0d want 2:32,33",
                  fl_dp_o.avail_num, fl_dp_o.tag[0], fl_dp_o.tag[1]);
      else n_pass++;
      drive(2, 0, 0, 0);
      tick();
      n_total++;
      if (fl_dp_o.tag[0] !== 6'd34 || fl_dp_o.tag[1] !== 6'd35)
         $display("FAIL rst_prio_pop got %0d,%0d want 34,35",
                  fl_dp_o.tag[0], fl_dp_o.tag[1]);
      else n_pass++;
   endtask

   initial begin
      idle();
      test_reset();
      test_drain();
      test_push_empty();
      test_back_to_back();
      test_wrap();
      test_rollback();
      test_reset_priority();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
